spi_slave_port: RTL



---
 rtl/spi_slave_port.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/spi_slave_port.sv
// spi_slave_port: SPI mode-0 slave that sends MSB first. The SPI pins are
// oversampled in the clk domain. Received bytes come out with a one-cycle
// strobe. Transmit bytes go through a single-entry valid/ready buffer.
module spi_slave_port #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_FILL   = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  input  logic                  spi_nss,
  output logic                  spi_miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  underrun,
  output logic                  frame_err
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    ACTIVE        = 2'd1,
    WAIT_NSS_HIGH = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sck_sync, nss_sync, mosi_sync, settle;
  logic                    sck_d, nss_d;
  logic                    sck_s, nss_s, mosi_s, settled;
  logic                    sck_rise, sck_fall, nss_rise, nss_fall;
  logic                    load_tx;
  logic [DATA_WIDTH-1:0]   buf_data, shift_out, rx_shift;
  logic                    buf_full, reload;
  logic [CNT_W-1:0]        bit_cnt;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign nss_s    = nss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign settled  = settle[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign nss_rise = nss_s & ~nss_d;
  assign nss_fall = ~nss_s & nss_d;
  assign busy     = ~nss_s;
  assign tx_ready = ~buf_full;

  // Synchronizer chains, the edge-detect delay flops and the settle marker.
  // The settle marker stops the reset value of nss being taken for a real
  // sample of the pin.
  always_ff @(posedge clk) begin
    // NOTE: every flop in a clocked block uses non-blocking assignment. All
    // chain stages then sample old values together, so the shift chain
    // behaves correctly.
    if (!rst_n) begin
      sck_sync  <= '0;
      nss_sync  <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      nss_d     <= 1'b1;
      settle    <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
      nss_sync  <= {nss_sync[SYNC_STAGES-2:0], spi_nss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_d     <= sck_s;
      nss_d     <= nss_s;
      settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // State register. After reset, the block waits for nss to go high, so it
  // ignores a frame that was already in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= WAIT_NSS_HIGH;
    else        state_q <= state_d;
  end

  // Next-state logic and shift-out load requests.
  always_comb begin
    // NOTE: every output of this block gets a default first. Any path that
    // leaves a signal unassigned would otherwise infer a latch.
    state_d = state_q;
    load_tx = 1'b0;
    case (state_q)
      WAIT_NSS_HIGH: if (settled && nss_s) state_d = IDLE;
      IDLE: begin
        if (nss_fall) begin
          state_d = ACTIVE;
          load_tx = 1'b1;
        end
      end
      ACTIVE: begin
        if (nss_rise)                state_d = IDLE;
        else if (sck_fall && reload) load_tx = 1'b1;
      end
      default: state_d = WAIT_NSS_HIGH;
    endcase
  end

  // Datapath: transmit buffer, shift registers, bit counter, strobes and miso.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_data  <= '0;
      buf_full  <= 1'b0;
      shift_out <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      bit_cnt   <= '0;
      reload    <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
      spi_miso  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
      spi_miso  <= (state_q == ACTIVE) ? shift_out[DATA_WIDTH-1] : 1'b0;

      // A load sees the buffer state from before any write in the same cycle.
      // There is no bypass path.
      if (tx_valid && !buf_full) begin
        buf_data <= tx_data;
        buf_full <= 1'b1;
      end else if (load_tx && buf_full) begin
        buf_full <= 1'b0;
      end

      if (load_tx) begin
        if (buf_full) begin
          shift_out <= buf_data;
        end else begin
          shift_out <= IDLE_FILL;
          underrun  <= 1'b1;
        end
        reload <= 1'b0;
      end

      if (state_q == IDLE && nss_fall) bit_cnt <= '0;

      if (state_q == ACTIVE) begin
        if (nss_rise) begin
          // A partial byte is dropped. A pending reload is abandoned, so the
          // buffer keeps its contents.
          if (bit_cnt != '0) frame_err <= 1'b1;
          bit_cnt <= '0;
          reload  <= 1'b0;
        end else begin
          if (bit_cnt == FULL_CNT) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            bit_cnt  <= '0;
            reload   <= 1'b1;
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
            bit_cnt  <= bit_cnt + CNT_W'(1);
          end
          if (sck_fall && !reload) shift_out <= {shift_out[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule
